nmr_pulse_table_sequencer: RTL and testbench
============================================

// Module: nmr_pulse_table_sequencer
// PURPOSE
//  Table-driven NMR pulse sequencer: plays up to DEPTH programmable steps, each a channel
//  mask held for a duration in microsecond ticks, optionally looped. Drives NCH gate lines,
//  a scope sync and a receiver blanking line. Sits between the PS register bank and the TX gates.
// PARAMETERS
//  TICK_DIV  125  clk cycles per time tick (1 us at 125 MHz)
//  DEPTH     16   number of table entries (power of 2)
//  NCH       2    number of pulse output channels
//  TW        32   width of step duration and blank length, in ticks
//  LW        16   width of loop counter
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 reset, synchronous, active-high
//  start      in   1                 1-cycle start request
//  abort      in   1                 stop sequence immediately
//  force_on   in   NCH               per-channel override, ORed into pulse_out
//  amp_on     in   1                 RF amp enabled; low forces blank_out high
//  wr_en      in   1                 table write strobe
//  wr_addr    in   $clog2(DEPTH)     table write address
//  wr_data    in   NCH+TW            {mask[NCH-1:0], dur[TW-1:0]}
//  n_steps    in   $clog2(DEPTH)+1   steps per pass (0..DEPTH)
//  loop_cnt   in   LW                extra passes; total passes = loop_cnt+1
//  blank_len  in   TW                post-pulse blank length in ticks
//  busy       out  1                 sequence running
//  done       out  1                 1-cycle pulse on normal completion
//  step_idx   out  $clog2(DEPTH)     current step index
//  sync_out   out  1                 high during step 0 of first pass, while busy
//  pulse_out  out  NCH               gate outputs
//  blank_out  out  1                 receiver blank
// BEHAVIOUR
//  Reset: IDLE; busy=0, done=0, step_idx=0, internal pulse reg=0, blank counter=0.
//   Table RAM not cleared. Outputs at reset: pulse_out=force_on, blank_out=~amp_on.
//  States: IDLE -> RUN -> IDLE via DONE (1 cycle, done=1). ABORT returns to IDLE.
//  IDLE: start=1 with n_steps!=0 -> RUN next cycle; n_steps, loop_cnt, blank_len latched.
//   Load step 0, divider=TICK_DIV-1, timer=max(dur,1), pass counter=loop_cnt.
//   start with n_steps==0 -> DONE next cycle, no pulse emitted.
//  RUN: internal mask reg = table[step_idx].mask, registered, valid the cycle RUN is entered.
//   Divider decrements every clk, reloads at 0. Timer decrements when divider==0.
//   Step ends when timer==1 and divider==0; each step lasts exactly max(dur,1)*TICK_DIV clks.
//   Step end: step_idx+1 if < n_steps-1. Else if pass counter !=0: decrement it, step_idx=0.
//   Else -> DONE. Steps are back-to-back; no idle cycle between steps or passes.
//  DONE: mask reg=0, done=1 for one cycle, then IDLE.
//  start while busy: ignored. wr_en while busy: write dropped (table frozen during run).
//  abort (any state, priority over start): mask reg=0 and IDLE next cycle, done stays 0.
//  Outputs: pulse_out = mask_reg | force_on. sync_out = busy & first pass & step_idx==0 & |mask_reg.
//  Blank: fall = (|mask_reg delayed 1 clk) & ~|mask_reg. On fall, counter=blank_len.
//   Counter decrements on divider==0 while nonzero. blank_out = fall | counter!=0 | ~amp_on.
//   Fall during active blank reloads (retrigger). blank_len=0 -> 1-cycle blank on fall.
//   Abort during pulse produces a normal fall and blank.
//  Arithmetic: counters unsigned, no wrap; dur=0 treated as 1 tick.
// TESTING
//  T1: DEPTH=4, table {01,10},{00,20},{01,5}, n_steps=3, loop=0, start
//      -> ch0 high 1250 clk, low 2500, high 625; done 1 clk after last step; busy low after.
//  T2: same, loop_cnt=2 -> 3 identical passes back-to-back, sync_out only in pass 0 step 0.
//  T3: blank_len=3, single pulse dur=2 -> blank_out high from fall for 1+3 ticks (~375+ clk);
//      amp_on=0 -> blank_out constant 1.
//  T4: abort at mid step 1 while ch1 high -> pulse_out=0 next clk, blank starts, done never.
//  T5: n_steps=0 start -> done after 1 clk, pulse_out stays 0; start/wr_en while busy ignored.
//  T6: rst mid-RUN -> IDLE, pulse_out=force_on, blank counter 0, step_idx 0 next cycle.

Source files
------------

// File: rtl/nmr_pulse_table_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : nmr_pulse_table_sequencer
// Brief  : Table-driven NMR pulse sequencer with looping, scope sync and
//          receiver blanking derived from pulse falling edges.
// Rev    : 1.0  initial release
// ============================================================================
module nmr_pulse_table_sequencer #(
    parameter int TICK_DIV = 125,
    parameter int DEPTH    = 16,
    parameter int NCH      = 2,
    parameter int TW       = 32,
    parameter int LW       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NCH-1:0]           force_on,
    input  logic                     amp_on,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [NCH+TW-1:0]        wr_data,
    input  logic [$clog2(DEPTH):0]   n_steps,
    input  logic [LW-1:0]            loop_cnt,
    input  logic [TW-1:0]            blank_len,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     sync_out,
    output logic [NCH-1:0]           pulse_out,
    output logic                     blank_out
);
    localparam int              c_aw      = $clog2(DEPTH);
    localparam int              c_dvw     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_dvw-1:0] c_div_max = c_dvw'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NCH+TW-1:0]    r_table [DEPTH];
    logic [NCH-1:0]       r_mask;
    logic                 r_mask_any_d;
    logic [c_dvw-1:0]     r_div;
    logic [TW-1:0]        r_timer;
    logic [TW-1:0]        r_blank_cnt;
    logic [TW-1:0]        r_blank_len;
    logic [LW-1:0]        r_pass;
    logic [c_aw-1:0]      r_step_idx;
    logic [c_aw:0]        r_n_steps;
    logic                 r_first_pass;

    logic                 w_launch;
    logic                 w_tick;
    logic                 w_step_end;
    logic                 w_more_steps;
    logic                 w_finish;
    logic                 w_fall;
    logic [c_aw:0]        w_idx_inc;
    logic [c_aw-1:0]      w_rd_idx;
    logic [NCH+TW-1:0]    w_entry;
    logic [NCH-1:0]       w_entry_mask;
    logic [TW-1:0]        w_entry_dur;

    assign w_tick       = (r_div == '0);
    assign w_step_end   = (r_state == S_RUN) && w_tick && (r_timer == TW'(1));
    assign w_idx_inc    = {1'b0, r_step_idx} + (c_aw+1)'(1);
    assign w_more_steps = (w_idx_inc < r_n_steps);
    assign w_finish     = w_step_end && !w_more_steps && (r_pass == '0);
    assign w_fall       = r_mask_any_d && (r_mask == '0);

    // Entry fetched for whichever step is about to be loaded (launch, advance or new pass)
    assign w_rd_idx     = (!w_launch && w_more_steps) ? w_idx_inc[c_aw-1:0] : '0;
    assign w_entry      = r_table[w_rd_idx];
    assign w_entry_mask = w_entry[NCH+TW-1:TW];
    assign w_entry_dur  = (w_entry[TW-1:0] == '0) ? TW'(1) : w_entry[TW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (n_steps != '0) begin
                            w_state_nxt = S_RUN;
                            w_launch    = 1'b1;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_RUN:   if (w_finish) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Table is frozen while a sequence runs
    always_ff @(posedge clk) begin
        if (wr_en && (r_state != S_RUN)) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask       <= '0;
            r_mask_any_d <= 1'b0;
            r_div        <= c_div_max;
            r_timer      <= '0;
            r_blank_cnt  <= '0;
            r_blank_len  <= '0;
            r_pass       <= '0;
            r_step_idx   <= '0;
            r_n_steps    <= '0;
            r_first_pass <= 1'b0;
        end else begin
            r_mask_any_d <= |r_mask;
            r_div        <= (w_launch || w_tick) ? c_div_max : r_div - c_dvw'(1);

            if (abort) begin
                r_mask     <= '0;
                r_step_idx <= '0;
            end else if (w_launch) begin
                r_n_steps    <= n_steps;
                r_pass       <= loop_cnt;
                r_blank_len  <= blank_len;
                r_first_pass <= 1'b1;
                r_step_idx   <= '0;
                r_mask       <= w_entry_mask;
                r_timer      <= w_entry_dur;
            end else if (r_state == S_RUN) begin
                if (w_step_end) begin
                    if (w_more_steps) begin
                        r_step_idx <= w_idx_inc[c_aw-1:0];
                        r_mask     <= w_entry_mask;
                        r_timer    <= w_entry_dur;
                    end else if (r_pass != '0) begin
                        r_pass       <= r_pass - LW'(1);
                        r_first_pass <= 1'b0;
                        r_step_idx   <= '0;
                        r_mask       <= w_entry_mask;
                        r_timer      <= w_entry_dur;
                    end else begin
                        r_mask     <= '0;
                        r_step_idx <= '0;
                    end
                end else if (w_tick) begin
                    r_timer <= r_timer - TW'(1);
                end
            end else if (r_state == S_DONE) begin
                r_mask <= '0;
            end

            // A new fall retriggers the blank window even if one is active
            if (w_fall) begin
                r_blank_cnt <= r_blank_len;
            end else if (w_tick && (r_blank_cnt != '0)) begin
                r_blank_cnt <= r_blank_cnt - TW'(1);
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign step_idx  = r_step_idx;
    assign sync_out  = busy && r_first_pass && (r_step_idx == '0) && (|r_mask);
    assign pulse_out = r_mask | force_on;
    assign blank_out = w_fall || (r_blank_cnt != '0) || !amp_on;

endmodule
`default_nettype wire

// File: tb/tb_nmr_pulse_table_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_nmr_pulse_table_sequencer
// Brief  : Self-checking bench: scenario table, corner sequences and random
//          stimulus against a step-list reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_nmr_pulse_table_sequencer;
    localparam int TD    = 4;
    localparam int DEPTH = 4;
    localparam int NCH   = 2;
    localparam int TW    = 8;
    localparam int LW    = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst, start, abort, amp_on, wr_en;
    logic [NCH-1:0]    force_on;
    logic [AW-1:0]     wr_addr;
    logic [NCH+TW-1:0] wr_data;
    logic [AW:0]       n_steps;
    logic [LW-1:0]     loop_cnt;
    logic [TW-1:0]     blank_len;
    logic              busy, done, sync_out, blank_out;
    logic [AW-1:0]     step_idx;
    logic [NCH-1:0]    pulse_out;

    always #5 clk = ~clk;

    nmr_pulse_table_sequencer #(
        .TICK_DIV(TD), .DEPTH(DEPTH), .NCH(NCH), .TW(TW), .LW(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .force_on(force_on),
        .amp_on(amp_on), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .n_steps(n_steps), .loop_cnt(loop_cnt), .blank_len(blank_len),
        .busy(busy), .done(done), .step_idx(step_idx), .sync_out(sync_out),
        .pulse_out(pulse_out), .blank_out(blank_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a run is expanded up front into one slot per clock
    typedef struct {
        logic [NCH-1:0] mask;
        int             idx;
        bit             first;
    } slot_t;
    slot_t          q[$];
    logic [NCH-1:0] tm_mask [DEPTH];
    int             tm_dur  [DEPTH];
    int             mode = 0;          // 0 idle, 1 running, 2 done
    logic [NCH-1:0] m_mask = '0;
    bit             m_prev_any = 1'b0;
    bit             m_first = 1'b0;
    int             m_idx = 0, m_cnt = 0, m_blen = 0, cyc = 0, m_ref = 0;
    int             st_busy, st_ch0, st_ch1, st_sync, st_blank, st_done;

    typedef struct {
        logic [7:0]  masks;   // {m3,m2,m1,m0}
        logic [31:0] durs;    // {d3,d2,d1,d0}
        int n, loops, blen;
        int e_busy, e_ch0, e_ch1, e_sync, e_blank;
    } rec_t;
    rec_t recs [5];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic load_slot();
        m_mask  = q[0].mask;
        m_idx   = q[0].idx;
        m_first = q[0].first;
    endtask

    task automatic expand();
        int d;
        q.delete();
        for (int p = 0; p <= int'(loop_cnt); p++) begin
            for (int i = 0; i < int'(n_steps); i++) begin
                d = (tm_dur[i] == 0) ? 1 : tm_dur[i];
                for (int k = 0; k < d * TD; k++)
                    q.push_back('{mask: tm_mask[i], idx: i, first: (p == 0)});
            end
        end
    endtask

    task automatic model_edge();
        bit tick, fall, was_run;
        tick    = ((cyc - m_ref) % TD) == TD - 1;
        fall    = m_prev_any && (m_mask == '0);
        was_run = (mode == 1);
        if (rst)                      m_cnt = 0;
        else if (fall)                m_cnt = m_blen;
        else if (tick && m_cnt != 0)  m_cnt = m_cnt - 1;
        m_prev_any = rst ? 1'b0 : (m_mask != '0);
        if (rst) begin
            mode = 0; m_mask = '0; m_idx = 0; m_first = 0; m_blen = 0;
            q.delete(); m_ref = cyc + 1;
        end else if (abort) begin
            mode = 0; m_mask = '0; m_idx = 0; q.delete();
        end else if (mode == 1) begin
            q.delete(0);
            if (q.size() == 0) begin
                mode = 2; m_mask = '0; m_idx = 0;
            end else begin
                load_slot();
            end
        end else if (mode == 2) begin
            mode = 0;
        end else if (start) begin
            if (n_steps != '0) begin
                expand(); mode = 1; m_ref = cyc + 1; m_blen = int'(blank_len); load_slot();
            end else begin
                mode = 2;
            end
        end
        if (wr_en && !was_run) begin
            tm_mask[wr_addr] = wr_data[NCH+TW-1:TW];
            tm_dur[wr_addr]  = int'(wr_data[TW-1:0]);
        end
        cyc++;
    endtask

    task automatic compare_cycle();
        logic [7:0] e, g;
        bit fall;
        fall = m_prev_any && (m_mask == '0);
        e = {mode == 1, mode == 2, AW'(m_idx),
             (mode == 1) && m_first && (m_idx == 0) && (m_mask != '0),
             m_mask | force_on, fall || (m_cnt != 0) || !amp_on};
        g = {busy, done, step_idx, sync_out, pulse_out, blank_out};
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL cycle %0d: got {busy,done,idx,sync,pulse,blank}=%b required %b", cyc, g, e);
        end
        if (busy === 1'b1)         st_busy++;
        if (pulse_out[0] === 1'b1) st_ch0++;
        if (pulse_out[1] === 1'b1) st_ch1++;
        if (sync_out === 1'b1)     st_sync++;
        if (blank_out === 1'b1)    st_blank++;
        if (done === 1'b1)         st_done++;
    endtask

    task automatic tick_check();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic program_entry(int i, logic [NCH-1:0] m, int d);
        wr_en = 1'b1; wr_addr = AW'(i); wr_data = {m, TW'(d)};
        tick_check();
        wr_en = 1'b0;
    endtask

    task automatic wait_done(string name);
        int g = 0;
        while (done !== 1'b1 && g < 2000) begin
            tick_check();
            g++;
        end
        check(name, 32'(g < 2000), 1);
    endtask

    task automatic clear_stats();
        st_busy = 0; st_ch0 = 0; st_ch1 = 0; st_sync = 0; st_blank = 0; st_done = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // T1, T2 loop, all-zero durations, T3 blank, zero-mask step
        recs[0] = '{8'b00_01_00_01, {8'd0, 8'd5, 8'd20, 8'd10}, 3, 0, 0, 140,  60,  0, 40,  2};
        recs[1] = '{8'b00_01_00_01, {8'd0, 8'd5, 8'd20, 8'd10}, 3, 2, 0, 420, 180,  0, 40,  4};
        recs[2] = '{8'b00_00_11_10, 32'd0,                      2, 1, 0,  16,   8, 16,  4,  1};
        recs[3] = '{8'b00_00_00_11, 32'd2,                      1, 0, 3,   8,   8,  8,  8, 12};
        recs[4] = '{8'b11_00_10_01, {8'd1, 8'd1, 8'd2, 8'd1},   4, 0, 1,  20,   8, 12,  4,  8};
        clear_stats();

        rst = 1'b1; start = 1'b0; abort = 1'b0; force_on = '0; amp_on = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; n_steps = '0; loop_cnt = '0; blank_len = '0;
        repeat (2) tick_check();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_idx", step_idx, 0);
        check("reset_blank", blank_out, 0);
        force_on = 2'b01; amp_on = 1'b0;
        tick_check();
        check("reset_pulse_force", pulse_out, 2'b01);
        check("reset_blank_ampoff", blank_out, 1);
        force_on = '0; amp_on = 1'b1; rst = 1'b0;
        tick_check();

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++)
                program_entry(i, recs[r].masks[2*i +: 2], int'(recs[r].durs[8*i +: 8]));
            n_steps = (AW+1)'(recs[r].n); loop_cnt = LW'(recs[r].loops);
            blank_len = TW'(recs[r].blen);
            clear_stats();
            start = 1'b1; tick_check(); start = 1'b0;
            wait_done($sformatf("rec%0d_done_seen", r));
            repeat (30) tick_check();
            check($sformatf("rec%0d_busy_clks", r),  st_busy,  recs[r].e_busy);
            check($sformatf("rec%0d_ch0_clks", r),   st_ch0,   recs[r].e_ch0);
            check($sformatf("rec%0d_ch1_clks", r),   st_ch1,   recs[r].e_ch1);
            check($sformatf("rec%0d_sync_clks", r),  st_sync,  recs[r].e_sync);
            check($sformatf("rec%0d_blank_clks", r), st_blank, recs[r].e_blank);
            check($sformatf("rec%0d_done_count", r), st_done,  1);
        end

        amp_on = 1'b0; tick_check();
        check("amp_off_blank", blank_out, 1);
        amp_on = 1'b1; tick_check();

        // Abort in the middle of step 1 while ch1 is high
        program_entry(0, 2'b01, 2);
        program_entry(1, 2'b10, 4);
        n_steps = 3'd2; loop_cnt = '0; blank_len = 8'd2;
        start = 1'b1; tick_check(); start = 1'b0;
        guard = 0;
        while (step_idx !== 2'd1 && guard < 200) begin tick_check(); guard++; end
        check("abort_reach_step1", 32'(guard < 200), 1);
        repeat (3) tick_check();
        check("abort_ch1_high", pulse_out, 2'b10);
        clear_stats();
        abort = 1'b1; tick_check(); abort = 1'b0;
        check("abort_pulse", pulse_out, 0);
        check("abort_busy", busy, 0);
        check("abort_blank", blank_out, 1);
        repeat (30) tick_check();
        check("abort_no_done", st_done, 0);

        // Empty program completes at once
        n_steps = '0; start = 1'b1; tick_check(); start = 1'b0;
        check("empty_done", done, 1);
        check("empty_busy", busy, 0);
        check("empty_pulse", pulse_out, 0);
        tick_check();
        check("empty_done_one_clk", done, 0);

        // Start and table write while running are both ignored
        program_entry(0, 2'b01, 3);
        n_steps = 3'd1; loop_cnt = '0; blank_len = '0;
        clear_stats();
        start = 1'b1; tick_check(); start = 1'b0;
        repeat (2) tick_check();
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = {2'b10, 8'd1};
        tick_check();
        start = 1'b0; wr_en = 1'b0;
        wait_done("busy_run_done_seen");
        check("busy_run_len", st_busy, 12);
        repeat (3) tick_check();
        start = 1'b1; tick_check(); start = 1'b0;
        check("frozen_table_mask", pulse_out, 2'b01);
        wait_done("frozen_run_done_seen");
        repeat (5) tick_check();

        // Reset in the middle of a run
        force_on = 2'b10;
        start = 1'b1; tick_check(); start = 1'b0;
        repeat (4) tick_check();
        rst = 1'b1; tick_check(); rst = 1'b0;
        check("rst_pulse_force", pulse_out, 2'b10);
        check("rst_idx", step_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_blank", blank_out, 0);
        force_on = '0;
        tick_check();

        // Random phase: reload short durations, then free-running stimulus
        for (int i = 0; i < DEPTH; i++)
            program_entry(i, NCH'($urandom_range(0, 3)), $urandom_range(0, 3));
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            abort     = ($urandom_range(0, 249) == 0);
            start     = ($urandom_range(0, 7) == 0);
            wr_en     = !start && ($urandom_range(0, 9) == 0);
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_data   = {NCH'($urandom_range(0, 3)), TW'($urandom_range(0, 3))};
            n_steps   = (AW+1)'($urandom_range(0, DEPTH));
            loop_cnt  = LW'($urandom_range(0, 2));
            blank_len = TW'($urandom_range(0, 3));
            force_on  = ($urandom_range(0, 7) == 0) ? NCH'($urandom_range(0, 3)) : '0;
            amp_on    = ($urandom_range(0, 15) != 0);
            tick_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
